// File: rtl/bpsk_demod.sv
// bpsk_demod: integrate-and-dump BPSK demodulator that packs decided bits MSB-first into words.
// Define BPSK_DEMOD_METRIC_EN to add the |final| confidence output 'metric'.
module bpsk_demod #(
  parameter int SAMPLE_NUMBER = 256,
  parameter int SAMPLE_WIDTH = 12,
  parameter int DATA_WIDTH = 12
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    sync,
  input  logic [SAMPLE_WIDTH-1:0] sample_in,
  output logic                    bit_out,
  output logic                    bit_valid,
  output logic [DATA_WIDTH-1:0]   data_out,
  output logic                    data_valid
`ifdef BPSK_DEMOD_METRIC_EN
  ,
  output logic [SAMPLE_WIDTH+$clog2(SAMPLE_NUMBER)-1:0] metric
`endif
);
  localparam int LW = $clog2(SAMPLE_NUMBER);
  localparam int AW = SAMPLE_WIDTH + LW + 1;
  localparam int MW = SAMPLE_WIDTH + LW;
  localparam int CW = $clog2(DATA_WIDTH + 1);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_nxt;
  logic [LW-1:0] k;
  logic signed [AW-1:0] acc, smp, final_v;
  logic [CW-1:0] cnt;
  logic [DATA_WIDTH-1:0] sreg, word;
  logic last, dec, word_done;
  assign smp = signed'({{(LW+1){1'b0}}, sample_in});
  always_comb begin
    state_nxt = (state == IDLE && en) ? RUN : state;
    last = en && !sync && k == LW'(SAMPLE_NUMBER - 1);
    final_v = acc - smp;
    dec = !final_v[AW-1] && |final_v;
    word = {sreg[DATA_WIDTH-2:0], dec};
    word_done = cnt == CW'(DATA_WIDTH - 1);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k <= '0;
      acc <= '0;
      cnt <= '0;
      sreg <= '0;
      bit_out <= 1'b0;
      bit_valid <= 1'b0;
      data_out <= '0;
      data_valid <= 1'b0;
    end else begin
      bit_valid <= last && state == RUN;
      data_valid <= last && state == RUN && word_done;
      // sync restarts the symbol; a coincident sample becomes k=0
      if (sync) begin
        k <= en ? LW'(1) : '0;
        acc <= en ? smp : '0;
        cnt <= '0;
        sreg <= '0;
      end else if (en) begin
        k <= k + LW'(1);
        acc <= last ? '0 : k[LW-1] ? acc - smp : acc + smp;
        if (last) begin
          bit_out <= dec;
          sreg <= word;
          cnt <= word_done ? '0 : cnt + CW'(1);
          if (word_done) data_out <= word;
        end
      end
    end
  end
`ifdef BPSK_DEMOD_METRIC_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) metric <= '0;
    else if (last) metric <= final_v[AW-1] ? MW'(-final_v) : MW'(final_v);
`endif
endmodule

// File: tb/tb_bpsk_demod.sv
// tb_bpsk_demod: directed, table-driven checks of bpsk_demod with a sine BPSK modulator model.
module tb_bpsk_demod;
  logic clk = 1'b0, rst_n = 1'b0, en = 1'b0, sync = 1'b0;
  logic [11:0] sample_in = 12'd2048;
  logic bit_out, bit_valid, data_valid;
  logic [11:0] data_out;
`ifdef BPSK_DEMOD_METRIC_EN
  logic [19:0] metric;
`endif
  int checks = 0, failures = 0, nbits = 0, nwords = 0;
  typedef struct {
    logic [11:0] word;
    logic        tog;
    logic [11:0] exp_data;
  } vec_t;
  vec_t tbl [5];

  always #5 clk = ~clk;

  bpsk_demod dut (
    .clk(clk), .rst_n(rst_n), .en(en), .sync(sync), .sample_in(sample_in),
    .bit_out(bit_out), .bit_valid(bit_valid), .data_out(data_out), .data_valid(data_valid)
`ifdef BPSK_DEMOD_METRIC_EN
    , .metric(metric)
`endif
  );

  always @(negedge clk) begin
    if (bit_valid) nbits++;
    if (data_valid) nwords++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic e, input logic s, input logic [11:0] x);
    en = e;
    sync = s;
    sample_in = x;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [11:0] smp(input logic b, input int k);
    real v;
    int a;
    v = 2047.0 * $sin(6.283185307179586 * k / 256.0);
    a = int'(v);
    return 12'(b ? 2048 + a : 2048 - a);
  endfunction

  task automatic send_sym(input logic b, input logic s0, input logic tog, input int n,
                          input logic wv, input logic [11:0] w);
    for (int k = 0; k < n; k++) begin
      step(1'b1, s0 && k == 0, smp(b, k));
      if (k == 254) chk("early_bit", bit_valid, 0);
      if (k == 255) begin
        chk("bit", {bit_valid, bit_out}, {1'b1, b});
        if (wv) chk("word", {data_valid, data_out}, {1'b1, w});
        else chk("no_word", data_valid, 0);
      end
      if (tog) begin
        step(1'b0, 1'b0, 12'd2048);
        if (k == 255) chk("bit_pulse", {bit_valid, data_valid}, 0);
      end
    end
  endtask

  task automatic send_word(input logic [11:0] w, input logic s0, input logic tog);
    for (int i = 0; i < 12; i++)
      send_sym(w[11-i], s0 && i == 0, tog, 256, i == 11, w);
  endtask

  initial begin
    int b0, w0;
    tbl[0] = '{12'hA5C, 1'b0, 12'hA5C};
    tbl[1] = '{12'h000, 1'b0, 12'h000};
    tbl[2] = '{12'h3C3, 1'b0, 12'h3C3};
    tbl[3] = '{12'h801, 1'b0, 12'h801};
    tbl[4] = '{12'hA5C, 1'b1, 12'hA5C};
    step(1'b0, 1'b0, 12'd2048);
    step(1'b0, 1'b0, 12'd2048);
    chk("reset_outs", {bit_out, bit_valid, data_valid, data_out}, 0);
`ifdef BPSK_DEMOD_METRIC_EN
    chk("reset_metric", metric, 0);
`endif
    rst_n = 1'b1;
    step(1'b0, 1'b0, 12'd2048);
    step(1'b0, 1'b0, 12'd2048);
    chk("idle_outs", {bit_valid, data_valid}, 0);
    // all-ones stream straight out of reset: bit at sample 256, word at 3072
    b0 = nbits; w0 = nwords;
    send_word(12'hFFF, 1'b0, 1'b0);
    step(1'b0, 1'b0, 12'd2048);
    chk("fff_bits", nbits - b0, 12);
    chk("fff_words", nwords - w0, 1);
    for (int i = 0; i < 5; i++) begin
      b0 = nbits; w0 = nwords;
      send_word(tbl[i].word, 1'b1, tbl[i].tog);
      step(1'b0, 1'b0, 12'd2048);
      chk("tbl_data", data_out, tbl[i].exp_data);
      chk("tbl_bits", nbits - b0, 12);
      chk("tbl_words", nwords - w0, 1);
    end
    // DC-only symbol cancels to exactly zero and must decide 0
    send_sym(1'b1, 1'b1, 1'b0, 256, 1'b0, 12'h0);
    for (int k = 0; k < 256; k++) step(1'b1, 1'b0, 12'd4095);
    chk("dc_tie", {bit_valid, bit_out}, 2'b10);
`ifdef BPSK_DEMOD_METRIC_EN
    chk("dc_metric", metric, 0);
`endif
    // reset in the middle of symbol 3
    send_sym(1'b1, 1'b1, 1'b0, 256, 1'b0, 12'h0);
    send_sym(1'b0, 1'b0, 1'b0, 256, 1'b0, 12'h0);
    send_sym(1'b1, 1'b0, 1'b0, 256, 1'b0, 12'h0);
    send_sym(1'b0, 1'b0, 1'b0, 100, 1'b0, 12'h0);
    #2 rst_n = 1'b0;
    #1 chk("async_reset", {bit_out, bit_valid, data_valid, data_out}, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    w0 = nwords;
    send_word(12'h5A3, 1'b0, 1'b0);
    step(1'b0, 1'b0, 12'd2048);
    chk("rst_words", nwords - w0, 1);
    // sync with en at k=200 drops five bits plus the partial symbol
    w0 = nwords;
    send_sym(1'b1, 1'b1, 1'b0, 256, 1'b0, 12'h0);
    send_sym(1'b0, 1'b0, 1'b0, 256, 1'b0, 12'h0);
    send_sym(1'b0, 1'b0, 1'b0, 256, 1'b0, 12'h0);
    send_sym(1'b1, 1'b0, 1'b0, 256, 1'b0, 12'h0);
    send_sym(1'b1, 1'b0, 1'b0, 256, 1'b0, 12'h0);
    send_sym(1'b1, 1'b0, 1'b0, 200, 1'b0, 12'h0);
    send_word(12'h3A5, 1'b1, 1'b0);
    step(1'b0, 1'b0, 12'd2048);
    chk("sync_words", nwords - w0, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/bpsk_demod.md
BPSK_DEMOD -- requirements
Module: bpsk_demod

Interface
REQ-001 SHALL have parameter SAMPLE_NUMBER, default 256: samples per symbol, a power of two and at least 4.
REQ-002 SHALL have parameter SAMPLE_WIDTH, default 12: width of the input sample.
REQ-003 SHALL have parameter DATA_WIDTH, default 12: bits per output word.
REQ-004 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port en, input, 1 bit: a sample is consumed on every clock edge where en=1.
REQ-007 SHALL have port sync, input, 1 bit: synchronous realignment of symbol and word boundaries.
REQ-008 SHALL have port sample_in, input, SAMPLE_WIDTH bits: unsigned offset-binary modulated sample, midscale 2^(SAMPLE_WIDTH-1).
REQ-009 SHALL have port bit_out, output, 1 bit: last decided symbol.
REQ-010 SHALL have port bit_valid, output, 1 bit: one-cycle pulse marking a new bit_out.
REQ-011 SHALL have port data_out, output, DATA_WIDTH bits: last assembled word.
REQ-012 SHALL have port data_valid, output, 1 bit: one-cycle pulse marking a new data_out.

Function
REQ-013 SHALL keep a sample index k in the range 0..SAMPLE_NUMBER-1 that advances only on cycles where en=1 and wraps from SAMPLE_NUMBER-1 to 0.
REQ-014 SHALL keep a signed accumulator of SAMPLE_WIDTH+log2(SAMPLE_NUMBER)+1 bits that never saturates or overflows.
REQ-015 SHALL add sample_in (zero-extended) to the accumulator when k < SAMPLE_NUMBER/2 and subtract it otherwise. Because both halves are equal length, the DC offset cancels exactly.
REQ-016 SHALL, on the consumed sample with k=SAMPLE_NUMBER-1, form final = acc - sample_in and clear the accumulator to 0.
REQ-017 SHALL set bit_out = 1 if final > 0 and bit_out = 0 if final <= 0; a tie decides 0.
REQ-018 SHALL update bit_out and pulse bit_valid high for exactly one cycle, one cycle after the edge that consumed k=SAMPLE_NUMBER-1.
REQ-019 SHALL leave k, the accumulator, the shift register and the bit count unchanged while en=0.
REQ-020 SHALL shift decided bits MSB-first into a DATA_WIDTH shift register, counting bits 0..DATA_WIDTH-1.
REQ-021 SHALL, on the DATA_WIDTH-th bit, update data_out and pulse data_valid in the same cycle as that bit's bit_valid, then restart the bit count at 0.
REQ-022 SHALL implement a state machine with states IDLE and RUN: IDLE -> RUN on the first edge with en=1; RUN stays in RUN; reset returns to IDLE.
REQ-023 SHALL, in IDLE, hold bit_valid=0 and data_valid=0.
REQ-024 SHALL, when sync=1, clear k, the accumulator and the bit count, and discard any partial word; a pending bit_valid or data_valid from the previous edge still completes.
REQ-025 SHALL, when sync=1 and en=1 occur together, take that sample as k=0, so the accumulator becomes +sample_in and k becomes 1.
REQ-026 SHALL give sync priority over the k=SAMPLE_NUMBER-1 decision: no bit is produced from that sample.

Reset
REQ-027 SHALL, while rst_n=0, asynchronously force state=IDLE, k=0, accumulator=0, bit count=0, shift register=0, bit_out=0, bit_valid=0, data_out=0 and data_valid=0.
REQ-028 SHALL, when reset asserts mid-symbol, discard the partial symbol and partial word; the first sample consumed after release is k=0.

Configuration
REQ-029 SHALL, when macro BPSK_DEMOD_METRIC_EN is defined, add output port metric of SAMPLE_WIDTH+log2(SAMPLE_NUMBER) bits equal to |final|, registered together with bit_out and reset to 0.
REQ-030 SHALL, when BPSK_DEMOD_METRIC_EN is undefined, omit the metric port and its logic, with all other behaviour identical.

Verification
REQ-031 SHALL cover: default parameters, sample_in = 2048 + 2047*sin(2*pi*k/256) for 12 symbols -> bit_valid at cycle 257 after first en, bit_out=1 each symbol, data_out=12'hFFF with data_valid at cycle 3073.
REQ-032 SHALL cover: feeding the output of the BPSK modulator stage carrying data 12'hA5C, with en=1 continuously and sync pulsed on its first sample -> data_out=12'hA5C with a single data_valid pulse.
REQ-033 SHALL cover: constant sample_in = 4095 for 256 samples -> final=0, bit_out=0 (DC cancels, tie rule); with BPSK_DEMOD_METRIC_EN defined, metric=0.
REQ-034 SHALL cover: en toggled 1/0 every cycle with the REQ-031 stream -> identical bit sequence, with the first bit_valid after 256 enabled samples.
REQ-035 SHALL cover: rst_n pulsed low at k=100 of symbol 3 -> all outputs 0 immediately; after release, bits realign to the new k=0 and no spurious data_valid occurs.
REQ-036 SHALL cover: sync=1 with en=1 at k=200 -> the partial word is dropped and the next bit_valid occurs 256 enabled samples later.
